// File: rtl/top_exhaustive_tester.sv
//==============================================================================
// Module      : top_exhaustive_tester
// Description : BIST driver for a 2-input/1-output unit. Walks all four input
//               vectors, captures a truth table and compares it to EXPECTED.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module top_exhaustive_tester #(
    parameter int         SETTLE_CYCLES = 2,
    parameter logic [3:0] EXPECTED      = 4'b0110
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rsp_z,
    output logic       drv_x,
    output logic       drv_y,
    output logic       busy,
    output logic       done,
    output logic [3:0] truth,
    output logic       pass,
    output logic [1:0] first_fail
);

    localparam int            CW       = $clog2(SETTLE_CYCLES) + 1;
    localparam logic [CW-1:0] C_RELOAD = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] C_ONE    = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [1:0]    r_vec;
    logic [1:0]    w_vec_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [3:0]    w_truth_nxt;
    logic          w_pass_nxt;
    logic [1:0]    w_ff_nxt;
    logic          w_busy_nxt;

    function automatic logic [1:0] f_lowest_set(input logic [3:0] m);
        casez (m)
            4'b???1: return 2'd0;
            4'b??10: return 2'd1;
            4'b?100: return 2'd2;
            4'b1000: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    always_comb begin
        w_state_nxt = r_state;
        w_vec_nxt   = r_vec;
        w_cnt_nxt   = r_cnt;
        w_truth_nxt = truth;
        w_pass_nxt  = pass;
        w_ff_nxt    = first_fail;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_SETTLE;
                    w_vec_nxt   = 2'd0;
                    w_cnt_nxt   = C_RELOAD;
                    w_truth_nxt = 4'd0;
                    w_pass_nxt  = 1'b0;
                    w_ff_nxt    = 2'd0;
                end
            end
            S_SETTLE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_SAMPLE;
                end else begin
                    w_cnt_nxt = r_cnt - C_ONE;
                end
            end
            S_SAMPLE: begin
                w_truth_nxt[r_vec] = rsp_z;
                if (r_vec != 2'd3) begin
                    w_vec_nxt   = r_vec + 2'd1;
                    w_cnt_nxt   = C_RELOAD;
                    w_state_nxt = S_SETTLE;
                end else begin
                    // Verdict uses the table including this final sample
                    w_state_nxt = S_DONE;
                    w_pass_nxt  = (w_truth_nxt == EXPECTED);
                    w_ff_nxt    = f_lowest_set(w_truth_nxt ^ EXPECTED);
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        w_busy_nxt = (w_state_nxt == S_SETTLE) || (w_state_nxt == S_SAMPLE);
    end

    // Outputs are registered from next-state values so they align with state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_vec      <= 2'd0;
            r_cnt      <= '0;
            truth      <= 4'd0;
            pass       <= 1'b0;
            first_fail <= 2'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            drv_x      <= 1'b0;
            drv_y      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_vec      <= w_vec_nxt;
            r_cnt      <= w_cnt_nxt;
            truth      <= w_truth_nxt;
            pass       <= w_pass_nxt;
            first_fail <= w_ff_nxt;
            busy       <= w_busy_nxt;
            done       <= (w_state_nxt == S_DONE);
            drv_x      <= w_busy_nxt & w_vec_nxt[0];
            drv_y      <= w_busy_nxt & w_vec_nxt[1];
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_top_exhaustive_tester.sv
//==============================================================================
// Module      : tb_top_exhaustive_tester
// Description : Scoreboard bench for top_exhaustive_tester with a modelled UUT.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_top_exhaustive_tester;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       rsp_z;
    logic       drv_x, drv_y, busy, done, pass;
    logic [3:0] truth;
    logic [1:0] first_fail;

    int mode = 0;
    int cyc = 0;
    int compared = 0;
    int mismatched = 0;

    typedef struct {
        logic [3:0] truth;
        logic       pass;
        logic [1:0] ff;
        int         done_cyc;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    top_exhaustive_tester #(
        .SETTLE_CYCLES(2),
        .EXPECTED     (4'b0110)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .rsp_z     (rsp_z),
        .drv_x     (drv_x),
        .drv_y     (drv_y),
        .busy      (busy),
        .done      (done),
        .truth     (truth),
        .pass      (pass),
        .first_fail(first_fail)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Unit-under-test model: XOR, stuck-at-1, or XOR with vector 2 flipped
    always_comb begin
        rsp_z = drv_x ^ drv_y;
        if (mode == 1) rsp_z = 1'b1;
        else if (mode == 2) rsp_z = (drv_x ^ drv_y) ^ ({drv_y, drv_x} == 2'd2);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", {31'd0, done}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("truth", {28'd0, truth}, {28'd0, e.truth});
                chk("pass", {31'd0, pass}, {31'd0, e.pass});
                chk("first_fail", {30'd0, first_fail}, {30'd0, e.ff});
                chk("done_cycle", cyc, e.done_cyc);
            end
        end
    end

    task automatic issue_start(input logic [3:0] t, input logic p, input logic [1:0] f,
                               input logic hold, output int s);
        exp_t x;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        s = cyc;
        if (!hold) start = 1'b0;
        x.truth = t; x.pass = p; x.ff = f; x.done_cyc = s + 12;
        sb.push_back(x);
    endtask

    task automatic drain();
        for (int i = 0; i < 80 && sb.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (sb.size() != 0) chk("drain_timeout", sb.size(), 32'd0);
        sb.delete();
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_zero(input string name);
        chk(name, {22'd0, busy, done, drv_y, drv_x, truth, pass, first_fail}, 32'd0);
    endtask

    initial begin
        int s;
        exp_t x;

        repeat (2) @(negedge clk);
        chk_zero("reset_state");
        rst = 1'b0;

        // Good XOR unit: drive walk and pass verdict
        mode = 0;
        issue_start(4'b0110, 1'b1, 2'd0, 1'b0, s);
        for (int k = 0; k < 12; k++) begin
            chk("walk_busy", {31'd0, busy}, 32'd1);
            chk("walk_drv", {30'd0, drv_y, drv_x}, k / 3);
            @(posedge clk);
            #1;
        end
        chk("busy_end", {31'd0, busy}, 32'd0);
        drain();

        // Reset while idle clears held results; no start keeps it idle
        @(negedge clk);
        rst = 1'b1;
        #2;
        chk_zero("rst_idle");
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk_zero("stay_idle");
        end

        // Stuck-at-1 response
        mode = 1;
        issue_start(4'b1111, 1'b0, 2'd0, 1'b0, s);
        drain();

        // Single fault at vector 2
        mode = 2;
        issue_start(4'b0010, 1'b0, 2'd2, 1'b0, s);
        drain();

        // Start during vector 1 ignored; held start restarts after DONE
        mode = 0;
        issue_start(4'b0110, 1'b1, 2'd0, 1'b0, s);
        wait_until(s + 3);
        start = 1'b1;
        x.truth = 4'b0110; x.pass = 1'b1; x.ff = 2'd0; x.done_cyc = s + 26;
        sb.push_back(x);
        wait_until(s + 13);
        chk("gap_busy", {31'd0, busy}, 32'd0);
        wait_until(s + 14);
        chk("restart_busy", {31'd0, busy}, 32'd1);
        wait_until(s + 15);
        start = 1'b0;
        drain();

        // Reset during SAMPLE of vector 2 aborts the run
        issue_start(4'b0110, 1'b1, 2'd0, 1'b0, s);
        wait_until(s + 8);
        chk("pre_abort_drv", {30'd0, drv_y, drv_x}, 32'd2);
        #2;
        rst = 1'b1;
        sb.delete();
        #1;
        chk_zero("rst_mid_run");
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk_zero("post_abort");
        issue_start(4'b0110, 1'b1, 2'd0, 1'b0, s);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
        $fatal(1);
    end

endmodule

`default_nettype wire
